// File: rtl/uart_send.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity, 1-2 stop bits.
// A one-byte holding register lets the next frame start on the edge the current one ends.
module uart_send #(
  parameter int CLKS_PER_BIT = 868,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] dat,
  input  logic       dat_en,
  output logic       tx,
  output logic       busy,
  output logic       active,
  output logic       done,
  output logic       ovf
);

  localparam int            CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LOAD  = CW'(CLKS_PER_BIT - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic          PAR_ODD   = 1'(PARITY_ODD);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic          stop_q, stop_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [7:0]    hold_q, hold_d;
  logic          busy_q, busy_d;
  logic          tx_q, tx_d;
  logic          done_q, done_d;
  logic          ovf_q, ovf_d;
  logic          bit_end, last_end;

  assign bit_end = (cnt_q == '0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      stop_q  <= 1'b0;
      shift_q <= '0;
      par_q   <= 1'b0;
      hold_q  <= '0;
      busy_q  <= 1'b0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      stop_q  <= stop_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      hold_q  <= hold_d;
      busy_q  <= busy_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    stop_d   = stop_q;
    shift_d  = shift_q;
    par_d    = par_q;
    hold_d   = hold_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    ovf_d    = 1'b0;
    last_end = 1'b0;
    // Timer reloads at every bit boundary and sits loaded while idle.
    cnt_d    = (bit_end || state_q == IDLE) ? BIT_LOAD : cnt_q - CW'(1);
    case (state_q)
      IDLE: begin
        if (dat_en) begin
          state_d = START;
          shift_d = dat;
          par_d   = ^dat ^ PAR_ODD;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          idx_d   = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            state_d = (PARITY_EN != 0) ? PARITY : STOP;
            stop_d  = 1'b0;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          stop_d  = 1'b0;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (stop_q == STOP_LAST) begin
            last_end = 1'b1;
            done_d   = 1'b1;
            if (busy_q) begin
              state_d = START;
              shift_d = hold_q;
              par_d   = ^hold_q ^ PAR_ODD;
              busy_d  = 1'b0;
            end else if (dat_en) begin
              state_d = START;
              shift_d = dat;
              par_d   = ^dat ^ PAR_ODD;
            end else begin
              state_d = IDLE;
            end
          end else begin
            stop_d = stop_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // On a drain edge with the holding register full, the incoming byte refills it.
    if (dat_en && state_q != IDLE) begin
      if (busy_q) begin
        if (last_end) begin
          hold_d = dat;
          busy_d = 1'b1;
        end else begin
          ovf_d = 1'b1;
        end
      end else if (!last_end) begin
        hold_d = dat;
        busy_d = 1'b1;
      end
    end
  end

  always_comb begin
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = par_d;
      default: tx_d = 1'b1;
    endcase
  end

  assign tx     = tx_q;
  assign busy   = busy_q;
  assign active = (state_q != IDLE);
  assign done   = done_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_uart_send.sv
// Bench for uart_send: four configurations (plain, even parity, odd parity, 2 stop) on shared stimulus;
// a serial decoder on the plain instance pops expected bytes from a scoreboard queue.
module tb_uart_send;

  logic       clk;
  logic       reset;
  logic [7:0] dat;
  logic       dat_en;
  logic [3:0] tx_w, busy_w, act_w, done_w, ovf_w;

  uart_send #(.CLKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_a (
    .clk(clk), .reset(reset), .dat(dat), .dat_en(dat_en),
    .tx(tx_w[0]), .busy(busy_w[0]), .active(act_w[0]), .done(done_w[0]), .ovf(ovf_w[0]));
  uart_send #(.CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_b (
    .clk(clk), .reset(reset), .dat(dat), .dat_en(dat_en),
    .tx(tx_w[1]), .busy(busy_w[1]), .active(act_w[1]), .done(done_w[1]), .ovf(ovf_w[1]));
  uart_send #(.CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_c (
    .clk(clk), .reset(reset), .dat(dat), .dat_en(dat_en),
    .tx(tx_w[2]), .busy(busy_w[2]), .active(act_w[2]), .done(done_w[2]), .ovf(ovf_w[2]));
  uart_send #(.CLKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_d (
    .clk(clk), .reset(reset), .dat(dat), .dat_en(dat_en),
    .tx(tx_w[3]), .busy(busy_w[3]), .active(act_w[3]), .done(done_w[3]), .ovf(ovf_w[3]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int nchk = 0;
  int nerr = 0;
  logic [7:0] sb[$];

  typedef struct {
    logic [7:0] dat;
    logic       par_even;
  } vec_t;
  vec_t vecs[6];

  logic [127:0] cap_tx[4];
  logic [127:0] cap_done[4];
  logic [127:0] cap_busy, cap_act, cap_ovf;

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  function automatic logic [127:0] ones(input int lo, input int hi);
    logic [127:0] m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  task automatic sample(input int j);
    for (int i = 0; i < 4; i++) begin
      cap_tx[i][j]   = tx_w[i];
      cap_done[i][j] = done_w[i];
    end
    cap_busy[j] = busy_w[0];
    cap_act[j]  = act_w[0];
    cap_ovf[j]  = ovf_w[0];
  endtask

  // Strobe lands on the next rising edge (edge k); returns at the falling edge after it (j=0).
  task automatic strobe(input logic [7:0] b);
    @(negedge clk);
    dat    = b;
    dat_en = 1'b1;
    @(negedge clk);
    dat_en = 1'b0;
  endtask

  task automatic capture(input int n);
    for (int j = 0; j < n; j++) begin
      sample(j);
      @(negedge clk);
    end
  endtask

  task automatic check_frame(input string nm, input logic [127:0] w, input logic [10:0] bits,
                             input int nb);
    for (int b = 0; b < nb; b++)
      chk($sformatf("%s_bit%0d", nm, b), 128'(w[4*b +: 4]), bits[b] ? 128'hF : 128'h0);
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((act_w != 4'h0 || busy_w != 4'h0) && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk("idle_timeout", 128'(t < 300), 128'(1));
    repeat (2) @(negedge clk);
  endtask

  // Serial decoder on the plain instance: mid-bit sampling, compares against the scoreboard.
  initial begin
    int mcnt;
    logic [7:0] mbits;
    logic [7:0] exp_b;
    mcnt  = -1;
    mbits = '0;
    forever begin
      @(negedge clk);
      if (reset !== 1'b1) begin
        mcnt = -1;
      end else if (mcnt < 0) begin
        if (tx_w[0] === 1'b0) mcnt = 0;
      end else begin
        mcnt++;
        if (mcnt >= 6 && mcnt <= 34 && ((mcnt - 6) % 4) == 0)
          mbits = {tx_w[0], mbits[7:1]};
        if (mcnt == 38) begin
          chk("mon_stop_bit", 128'(tx_w[0]), 128'(1));
          if (sb.size() == 0) begin
            chk("sb_unexpected_byte", 128'(mbits), 128'h1ff);
          end else begin
            exp_b = sb.pop_front();
            chk("sb_byte", 128'(mbits), 128'(exp_b));
          end
          mcnt = -1;
        end
      end
    end
  end

  initial begin
    logic [10:0] fa, fb, fc, fd;
    vecs[0] = '{8'hA5, 1'b0};
    vecs[1] = '{8'h01, 1'b1};
    vecs[2] = '{8'hFF, 1'b0};
    vecs[3] = '{8'h80, 1'b1};
    vecs[4] = '{8'h00, 1'b0};
    vecs[5] = '{8'h37, 1'b1};

    reset  = 1'b0;
    dat    = 8'h00;
    dat_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx",     128'(tx_w),   128'(4'hF));
    chk("rst_busy",   128'(busy_w), 128'(4'h0));
    chk("rst_active", 128'(act_w),  128'(4'h0));
    chk("rst_done",   128'(done_w), 128'(4'h0));
    chk("rst_ovf",    128'(ovf_w),  128'(4'h0));
    // Strobe held during reset must be ignored.
    dat    = 8'hAA;
    dat_en = 1'b1;
    @(negedge clk);
    chk("rst_prio_active", 128'(act_w), 128'(4'h0));
    chk("rst_prio_tx",     128'(tx_w),  128'(4'hF));
    dat_en = 1'b0;
    reset  = 1'b1;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      sb.push_back(vecs[v].dat);
      strobe(vecs[v].dat);
      capture(46);
      fa = {2'b11, vecs[v].dat, 1'b0};
      fb = {1'b1, vecs[v].par_even, vecs[v].dat, 1'b0};
      fc = {1'b1, ~vecs[v].par_even, vecs[v].dat, 1'b0};
      fd = {2'b11, vecs[v].dat, 1'b0};
      check_frame($sformatf("v%0d_plain", v), cap_tx[0], fa, 10);
      check_frame($sformatf("v%0d_even", v),  cap_tx[1], fb, 11);
      check_frame($sformatf("v%0d_odd", v),   cap_tx[2], fc, 11);
      check_frame($sformatf("v%0d_stop2", v), cap_tx[3], fd, 11);
      chk($sformatf("v%0d_done_plain", v), cap_done[0] & ones(0, 45), ones(40, 40));
      chk($sformatf("v%0d_done_even", v),  cap_done[1] & ones(0, 45), ones(44, 44));
      chk($sformatf("v%0d_done_odd", v),   cap_done[2] & ones(0, 45), ones(44, 44));
      chk($sformatf("v%0d_done_stop2", v), cap_done[3] & ones(0, 45), ones(44, 44));
      chk($sformatf("v%0d_active", v),     cap_act & ones(0, 45), ones(0, 39));
    end

    // Back-to-back: second byte parked in holding register, no idle gap.
    sb.push_back(8'h55);
    sb.push_back(8'h0F);
    strobe(8'h55);
    for (int j = 0; j < 86; j++) begin
      sample(j);
      if (j == 4) begin
        dat    = 8'h0F;
        dat_en = 1'b1;
      end else begin
        dat_en = 1'b0;
      end
      @(negedge clk);
    end
    chk("b2b_busy",   cap_busy & ones(0, 85), ones(5, 39));
    chk("b2b_active", cap_act & ones(0, 85), ones(0, 79));
    chk("b2b_done",   cap_done[0] & ones(0, 85), ones(40, 40) | ones(80, 80));
    chk("b2b_gap",    128'(cap_tx[0][40:39]), 128'(2'b01));
    wait_idle();

    // Overflow: third strobe while holding register full is dropped.
    sb.push_back(8'h11);
    sb.push_back(8'h22);
    strobe(8'h11);
    for (int j = 0; j < 86; j++) begin
      sample(j);
      dat_en = 1'b0;
      if (j == 1) begin
        dat    = 8'h22;
        dat_en = 1'b1;
      end else if (j == 2) begin
        dat    = 8'h33;
        dat_en = 1'b1;
      end
      @(negedge clk);
    end
    chk("ovf_pulse", cap_ovf & ones(0, 85), ones(3, 3));
    chk("ovf_busy",  cap_busy & ones(0, 85), ones(2, 39));
    chk("ovf_done",  cap_done[0] & ones(0, 85), ones(40, 40) | ones(80, 80));
    wait_idle();

    // Reset mid-frame with a byte waiting: frame aborted, held byte discarded.
    strobe(8'hFF);
    for (int j = 0; j < 21; j++) begin
      sample(j);
      dat_en = 1'b0;
      if (j == 1) begin
        dat    = 8'h3C;
        dat_en = 1'b1;
      end
      reset = (j == 12 || j == 13) ? 1'b0 : 1'b1;
      @(negedge clk);
    end
    chk("mrst_busy",   cap_busy & ones(0, 20), ones(2, 12));
    chk("mrst_active", cap_act & ones(0, 20), ones(0, 12));
    chk("mrst_tx",     cap_tx[0] & ones(13, 20), ones(13, 20));
    chk("mrst_tx_d",   cap_tx[3] & ones(13, 20), ones(13, 20));
    sb.push_back(8'h00);
    strobe(8'h00);
    capture(46);
    fa = {2'b11, 8'h00, 1'b0};
    check_frame("mrst_clean", cap_tx[0], fa, 10);
    chk("mrst_clean_done", cap_done[0] & ones(0, 45), ones(40, 40));
    wait_idle();

    chk("sb_drained", 128'(sb.size()), 128'(0));
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
